// File: rtl/cache_axi_pkg.sv
// AXI read-channel constants and refill FSM states shared by the refill engines and the read merge.
package cache_axi_pkg;

    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] LOCK_NORMAL = 2'b00;
    localparam logic [3:0] CACHE_NONE  = 4'b0000;
    localparam logic [2:0] PROT_NONE   = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_FILL = 2'd3
    } refill_state_e;

endpackage

// File: rtl/axi_refill_ctrl_if.sv
// Miss request, AXI read address/data and line-refill signals of one cache refill engine.
interface axi_refill_ctrl_if #(
    parameter int unsigned LINE_WORDS = 16
);
    logic                      miss_req;
    logic [31:0]               miss_addr;
    logic                      miss_ack;
    logic                      busy;
    logic                      ren;
    logic [3:0]                arid;
    logic [31:0]               araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic [1:0]                arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [31:0]               rdata;
    logic                      rlast;
    logic                      rvalid;
    logic                      refill_valid;
    logic                      refill_ready;
    logic [31:0]               refill_addr;
    logic [32*LINE_WORDS-1:0]  refill_data;
    logic                      refill_err;

    // Refill engine side
    modport master (
        input  miss_req, miss_addr, arready, rdata, rlast, rvalid, refill_ready,
        output miss_ack, busy, ren, arid, araddr, arlen, arsize, arburst, arlock,
               arcache, arprot, arvalid, refill_valid, refill_addr, refill_data, refill_err
    );

    // Cache / merge side
    modport slave (
        output miss_req, miss_addr, arready, rdata, rlast, rvalid, refill_ready,
        input  miss_ack, busy, ren, arid, araddr, arlen, arsize, arburst, arlock,
               arcache, arprot, arvalid, refill_valid, refill_addr, refill_data, refill_err
    );

endinterface

// File: rtl/refill_line_buf.sv
// LINE_WORDS x 32 line buffer: single write port, whole line read as a flat bus.
module refill_line_buf #(
    parameter int unsigned WORDS = 16,
    parameter int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [31:0]           wdata,
    output logic [32*WORDS-1:0]   rdata_flat
);

    logic [WORDS-1:0][31:0] mem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata_flat = mem_q;

endmodule

// File: rtl/axi_refill_ctrl.sv
// Cache line-refill engine: one aligned INCR read burst per miss, line presented in a single handshake.
module axi_refill_ctrl
    import cache_axi_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 16,
    parameter logic [3:0]  ARID       = 4'h0
) (
    input  logic             clk,
    input  logic             reset,
    axi_refill_ctrl_if.master bus
);

    localparam int unsigned   OFF_W   = $clog2(LINE_WORDS * 4);
    localparam int unsigned   CNT_W   = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINE_WORDS - 1);
    localparam logic [31:0]   OFF_MASK = 32'((1 << OFF_W) - 1);

    refill_state_e     state_q, state_d;
    logic              ack_q, ack_d;
    logic              arvalid_q, arvalid_d;
    logic              ren_q, ren_d;
    logic              busy_q, busy_d;
    logic              refill_valid_q, refill_valid_d;
    logic [31:0]       line_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              full_q;
    logic              err_q;
    logic              beat_we;
    logic              fill_done;

    // State and registered FSM outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ack_q          <= 1'b0;
            arvalid_q      <= 1'b0;
            ren_q          <= 1'b0;
            busy_q         <= 1'b0;
            refill_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ack_q          <= ack_d;
            arvalid_q      <= arvalid_d;
            ren_q          <= ren_d;
            busy_q         <= busy_d;
            refill_valid_q <= refill_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.miss_req)                state_d = ST_AR;
            ST_AR:   if (bus.arready)                 state_d = ST_R;
            ST_R:    if (bus.rvalid && bus.rlast)     state_d = ST_FILL;
            ST_FILL: if (bus.refill_ready)            state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the flops line up with the state register
    always_comb begin
        ack_d          = 1'b0;
        arvalid_d      = 1'b0;
        ren_d          = 1'b0;
        busy_d         = 1'b0;
        refill_valid_d = 1'b0;
        ack_d          = (state_q == ST_IDLE) && bus.miss_req;
        arvalid_d      = (state_d == ST_AR);
        ren_d          = (state_d == ST_AR) || (state_d == ST_R);
        busy_d         = (state_d != ST_IDLE);
        refill_valid_d = (state_d == ST_FILL);
    end

    // full_q marks the last slot written; later beats are dropped until rlast
    assign beat_we   = (state_q == ST_R) && bus.rvalid && !full_q;
    assign fill_done = (state_q == ST_FILL) && bus.refill_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_addr_q <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && bus.miss_req) begin
                line_addr_q <= bus.miss_addr & ~OFF_MASK;
            end
            if (fill_done) begin
                cnt_q  <= '0;
                full_q <= 1'b0;
                err_q  <= 1'b0;
            end else if (beat_we) begin
                if (cnt_q == CNT_MAX) begin
                    full_q <= 1'b1;
                    if (!bus.rlast) err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.rlast) err_q <= 1'b1;
                end
            end
        end
    end

    refill_line_buf #(
        .WORDS (LINE_WORDS),
        .IDX_W (CNT_W)
    ) u_line_buf (
        .clk        (clk),
        .reset      (reset),
        .we         (beat_we),
        .widx       (cnt_q),
        .wdata      (bus.rdata),
        .rdata_flat (bus.refill_data)
    );

    assign bus.miss_ack     = ack_q;
    assign bus.busy         = busy_q;
    assign bus.ren          = ren_q;
    assign bus.arvalid      = arvalid_q;
    assign bus.refill_valid = refill_valid_q;
    assign bus.araddr       = line_addr_q;
    assign bus.refill_addr  = line_addr_q;
    assign bus.refill_err   = err_q;
    assign bus.arid         = ARID;
    assign bus.arlen        = 8'(LINE_WORDS - 1);
    assign bus.arsize       = SIZE_4B;
    assign bus.arburst      = BURST_INCR;
    assign bus.arlock       = LOCK_NORMAL;
    assign bus.arcache      = CACHE_NONE;
    assign bus.arprot       = PROT_NONE;

endmodule

// File: tb/tb_axi_refill_ctrl.sv
// Randomized bench for axi_refill_ctrl against a line-buffer/burst reference model.
module tb_axi_refill_ctrl;

    localparam int unsigned LW = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ack_cnt = 0;

    logic [31:0] exp_line [LW];

    axi_refill_ctrl_if #(.LINE_WORDS(LW)) bus ();

    axi_refill_ctrl #(.LINE_WORDS(LW), .ARID(4'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Independent count of acknowledge pulses seen by the cache
    always @(posedge clk) if (bus.miss_ack === 1'b1) ack_cnt++;

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    function automatic logic [32*LW-1:0] exp_flat();
        logic [32*LW-1:0] f;
        for (int i = 0; i < int'(LW); i++) f[32*i +: 32] = exp_line[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] a);
        bus.miss_req  = 1'b1;
        bus.miss_addr = a;
        tick();
        n_tests++;
        if (bus.miss_ack !== 1'b1 || bus.arvalid !== 1'b1 || bus.araddr !== align(a)) begin
            n_fail++;
            $display("FAIL miss_to_ar: ack=%0b arvalid=%0b araddr=%h want 1 1 %h",
                     bus.miss_ack, bus.arvalid, bus.araddr, align(a));
        end
        bus.miss_req  = 1'b0;
        bus.miss_addr = $urandom;
    endtask

    task automatic accept_ar(input int hold);
        repeat (hold) tick();
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
    endtask

    // Beats first..first+cnt-1 of a burst of length total; model keeps only the first LW beats
    task automatic send_beats(input int first, input int cnt, input int total,
                              input bit seq, input int max_gap);
        for (int k = first; k < first + cnt; k++) begin
            logic [31:0] d;
            d = seq ? 32'hA000_0000 + 32'(k) : $urandom;
            repeat ($urandom_range(max_gap, 0)) begin
                bus.rvalid = 1'b0;
                tick();
            end
            bus.rvalid = 1'b1;
            bus.rdata  = d;
            bus.rlast  = (k == total - 1);
            if (k < int'(LW)) exp_line[k] = d;
            tick();
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
            bus.rdata  = $urandom;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({bus.miss_ack, bus.busy, bus.ren, bus.arvalid, bus.refill_valid, bus.refill_err} !== 6'b0
            || bus.araddr !== 32'h0 || bus.refill_addr !== 32'h0 || bus.refill_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ack/busy/ren/arv/rv/err=%b araddr=%h raddr=%h want all 0",
                     {bus.miss_ack, bus.busy, bus.ren, bus.arvalid, bus.refill_valid, bus.refill_err},
                     bus.araddr, bus.refill_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ar_issue();
        start_miss(32'h1fc0_0134);
        n_tests++;
        if (bus.araddr !== 32'h1fc0_0100 || bus.arlen !== 8'h0f || bus.arsize !== 3'b010
            || bus.arburst !== 2'b01 || bus.ren !== 1'b1 || bus.busy !== 1'b1 || bus.arid !== 4'h0
            || bus.arlock !== 2'b00 || bus.arcache !== 4'b0000 || bus.arprot !== 3'b000) begin
            n_fail++;
            $display("FAIL ar_fields: araddr=%h arlen=%h arsize=%b arburst=%b ren=%b busy=%b want 1fc00100 0f 010 01 1 1",
                     bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.ren, bus.busy);
        end
        // arready held low; a stray beat in AR must not reach the buffer
        for (int c = 0; c < 5; c++) begin
            bus.rvalid = (c == 2);
            bus.rdata  = 32'hDEAD_BEEF;
            tick();
            bus.rvalid = 1'b0;
            n_tests++;
            if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1fc0_0100 || bus.miss_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL ar_hold_%0d: arvalid=%b araddr=%h ack=%b want 1 1fc00100 0",
                         c, bus.arvalid, bus.araddr, bus.miss_ack);
            end
        end
        accept_ar(0);
        n_tests++;
        if (bus.arvalid !== 1'b0 || bus.ren !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_accept: arvalid=%b ren=%b busy=%b want 0 1 1", bus.arvalid, bus.ren, bus.busy);
        end
    endtask

    task automatic test_full_burst();
        send_beats(0, LW, LW, 1'b1, 3);
        n_tests++;
        if (bus.refill_valid !== 1'b1 || bus.ren !== 1'b0 || bus.refill_err !== 1'b0
            || bus.refill_addr !== 32'h1fc0_0100) begin
            n_fail++;
            $display("FAIL burst_fill: valid=%b ren=%b err=%b addr=%h want 1 0 0 1fc00100",
                     bus.refill_valid, bus.ren, bus.refill_err, bus.refill_addr);
        end
        n_tests++;
        if (bus.refill_data !== exp_flat()) begin
            n_fail++;
            $display("FAIL burst_data: got %h want %h", bus.refill_data, exp_flat());
        end
        bus.refill_ready = 1'b1;
        tick();
        bus.refill_ready = 1'b0;
        n_tests++;
        if (bus.refill_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_release: valid=%b busy=%b want 0 0", bus.refill_valid, bus.busy);
        end
    endtask

    task automatic test_early_rlast();
        logic [31:0] a;
        a = $urandom;
        start_miss(a);
        accept_ar($urandom_range(3, 0));
        send_beats(0, 8, 8, 1'b0, 2);
        n_tests++;
        if (bus.refill_valid !== 1'b1 || bus.refill_err !== 1'b1 || bus.refill_data !== exp_flat()) begin
            n_fail++;
            $display("FAIL short_fill: valid=%b err=%b data=%h want 1 1 %h",
                     bus.refill_valid, bus.refill_err, bus.refill_data, exp_flat());
        end
        // Stalled cache with stray beats arriving: line must not change
        for (int c = 0; c < 3; c++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = $urandom;
            tick();
            bus.rvalid = 1'b0;
            n_tests++;
            if (bus.refill_valid !== 1'b1 || bus.refill_err !== 1'b1 || bus.refill_addr !== align(a)
                || bus.refill_data !== exp_flat()) begin
                n_fail++;
                $display("FAIL fill_stable_%0d: valid=%b err=%b addr=%h want 1 1 %h",
                         c, bus.refill_valid, bus.refill_err, bus.refill_addr, align(a));
            end
        end
        bus.refill_ready = 1'b1;
        tick();
        bus.refill_ready = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.refill_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL short_release: busy=%b valid=%b want 0 0", bus.busy, bus.refill_valid);
        end
    endtask

    task automatic test_random_lines();
        for (int it = 0; it < 12; it++) begin
            logic [31:0] a;
            int n;
            int waited;
            a = $urandom;
            n = ($urandom_range(1, 0) == 1) ? int'(LW) : $urandom_range(20, 1);
            start_miss(a);
            accept_ar($urandom_range(4, 0));
            send_beats(0, n, n, 1'b0, 2);
            waited = 0;
            while (bus.refill_valid !== 1'b1 && waited < 8) begin
                tick();
                waited++;
            end
            n_tests++;
            if (waited != 0 || bus.refill_data !== exp_flat() || bus.refill_err !== (n != int'(LW))
                || bus.refill_addr !== align(a)) begin
                n_fail++;
                $display("FAIL rand_line_%0d: n=%0d wait=%0d err=%b addr=%h data=%h want 0 %b %h %h",
                         it, n, waited, bus.refill_err, bus.refill_addr, bus.refill_data,
                         (n != int'(LW)), align(a), exp_flat());
            end
            repeat ($urandom_range(2, 0)) tick();
            bus.refill_ready = 1'b1;
            tick();
            bus.refill_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        int acks;
        a = $urandom;
        b = $urandom;
        start_miss(a);
        accept_ar(1);
        acks = ack_cnt;
        bus.miss_req  = 1'b1;
        bus.miss_addr = b;
        send_beats(0, 5, LW, 1'b0, 1);
        send_beats(5, LW - 5, LW, 1'b0, 1);
        repeat (2) tick();
        n_tests++;
        if (ack_cnt != acks || bus.refill_valid !== 1'b1 || bus.refill_addr !== align(a)) begin
            n_fail++;
            $display("FAIL busy_ignore: acks=%0d valid=%b addr=%h want %0d 1 %h",
                     ack_cnt, bus.refill_valid, bus.refill_addr, acks, align(a));
        end
        bus.refill_ready = 1'b1;
        tick();
        bus.refill_ready = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.miss_ack !== 1'b0 || bus.refill_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b ack=%b valid=%b want 0 0 0", bus.busy, bus.miss_ack, bus.refill_valid);
        end
        tick();
        n_tests++;
        if (bus.miss_ack !== 1'b1 || bus.arvalid !== 1'b1 || bus.araddr !== align(b)) begin
            n_fail++;
            $display("FAIL b2b_ack: ack=%b arvalid=%b araddr=%h want 1 1 %h",
                     bus.miss_ack, bus.arvalid, bus.araddr, align(b));
        end
        bus.miss_req = 1'b0;
        accept_ar(2);
        send_beats(0, LW, LW, 1'b0, 2);
        n_tests++;
        if (bus.refill_valid !== 1'b1 || bus.refill_err !== 1'b0 || bus.refill_data !== exp_flat()
            || bus.refill_addr !== align(b)) begin
            n_fail++;
            $display("FAIL b2b_line: valid=%b err=%b addr=%h data=%h want 1 0 %h %h",
                     bus.refill_valid, bus.refill_err, bus.refill_addr, bus.refill_data, align(b), exp_flat());
        end
        bus.refill_ready = 1'b1;
        tick();
        bus.refill_ready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] a;
        start_miss($urandom);
        accept_ar(0);
        send_beats(0, 7, LW, 1'b0, 1);
        reset = 1'b1;
        tick();
        for (int i = 0; i < int'(LW); i++) exp_line[i] = 32'h0;
        n_tests++;
        if (bus.ren !== 1'b0 || bus.arvalid !== 1'b0 || bus.refill_valid !== 1'b0 || bus.busy !== 1'b0
            || bus.refill_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: ren=%b arvalid=%b valid=%b busy=%b want 0 0 0 0",
                     bus.ren, bus.arvalid, bus.refill_valid, bus.busy);
        end
        reset = 1'b0;
        tick();
        a = $urandom;
        start_miss(a);
        accept_ar(1);
        send_beats(0, LW, LW, 1'b0, 2);
        n_tests++;
        if (bus.refill_valid !== 1'b1 || bus.refill_err !== 1'b0 || bus.refill_data !== exp_flat()
            || bus.refill_addr !== align(a)) begin
            n_fail++;
            $display("FAIL post_reset_line: valid=%b err=%b addr=%h data=%h want 1 0 %h %h",
                     bus.refill_valid, bus.refill_err, bus.refill_addr, bus.refill_data, align(a), exp_flat());
        end
        bus.refill_ready = 1'b1;
        tick();
        bus.refill_ready = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.miss_req     = 1'b0;
        bus.miss_addr    = 32'h0;
        bus.arready      = 1'b0;
        bus.rdata        = 32'h0;
        bus.rlast        = 1'b0;
        bus.rvalid       = 1'b0;
        bus.refill_ready = 1'b0;
        for (int i = 0; i < int'(LW); i++) exp_line[i] = 32'h0;
        test_reset();
        test_ar_issue();
        test_full_burst();
        test_early_rlast();
        test_random_lines();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
